// File: rtl/tt_autosel_pkg.sv
// Shared definitions for the autosel block family: sequencer states and
// default phase lengths used by tt_autosel and tt_sel_pulser.
package tt_autosel_pkg;

  localparam int unsigned DEF_ADDR_W      = 10;
  localparam int unsigned DEF_RST_CYCLES  = 4;
  localparam int unsigned DEF_HALF_PERIOD = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_GAP    = 3'd2,
    ST_INC_HI = 3'd3,
    ST_INC_LO = 3'd4,
    ST_ENA    = 3'd5
  } sel_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_sel_timer.sv
// Loadable phase down-counter; expired_o is high once a loaded length of
// len_i cycles has fully elapsed (immediately true for len_i == 1).
module tt_sel_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] len_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = len_i - W'(1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_o <= 1'b1;
    end else begin
      cnt_q     <= cnt_d;
      expired_o <= (cnt_d == '0);
    end
  end

endmodule

// File: rtl/tt_sel_pulser.sv
// Mux-selection sequencer: resets the mux select counter, emits req_addr
// increment pulses on ctrl_sel_inc, then raises ctrl_ena.
module tt_sel_pulser
  import tt_autosel_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned HALF_PERIOD = DEF_HALF_PERIOD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              done,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int unsigned MAX_LEN = max_u(RST_CYCLES, HALF_PERIOD);
  localparam int unsigned TW      = $clog2(MAX_LEN + 1);

  sel_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pulse_q, pulse_d;
  logic              tmr_load;
  logic [TW-1:0]     tmr_len;
  logic              tmr_expired;

  logic sel_rst_n_q, sel_rst_n_d;
  logic inc_q, inc_d;
  logic ena_q, ena_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_ENA);

  tt_sel_timer #(.W(TW)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .len_i     (tmr_len),
    .expired_o (tmr_expired)
  );

  // Next state, pulse counter and timer control.
  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    tmr_load = 1'b0;
    tmr_len  = TW'(HALF_PERIOD);
    unique case (state_q)
      ST_IDLE, ST_ENA: begin
        if (req_valid) begin
          state_d  = ST_RST;
          pulse_d  = req_addr;
          tmr_load = 1'b1;
          tmr_len  = TW'(RST_CYCLES);
        end
      end
      ST_RST: begin
        if (tmr_expired) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
        end
      end
      ST_GAP: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          state_d  = (pulse_q != '0) ? ST_INC_HI : ST_ENA;
        end
      end
      ST_INC_HI: begin
        if (tmr_expired) begin
          state_d  = ST_INC_LO;
          tmr_load = 1'b1;
        end
      end
      ST_INC_LO: begin
        if (tmr_expired) begin
          pulse_d  = pulse_q - ADDR_W'(1);
          tmr_load = 1'b1;
          state_d  = (pulse_q != ADDR_W'(1)) ? ST_INC_HI : ST_ENA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pad values follow the current state one edge later, so nothing moves on the accept edge.
  always_comb begin
    sel_rst_n_d = !((state_q == ST_IDLE) || (state_q == ST_RST));
    inc_d       = (state_q == ST_INC_HI);
    ena_d       = (state_q == ST_ENA);
    busy_d      = (state_q == ST_RST) || (state_q == ST_GAP) ||
                  (state_q == ST_INC_HI) || (state_q == ST_INC_LO);
    done_d      = (state_q == ST_ENA) && !ena_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pulse_q     <= '0;
      sel_rst_n_q <= 1'b0;
      inc_q       <= 1'b0;
      ena_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_q     <= pulse_d;
      sel_rst_n_q <= sel_rst_n_d;
      inc_q       <= inc_d;
      ena_q       <= ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ctrl_sel_rst_n = sel_rst_n_q;
  assign ctrl_sel_inc   = inc_q;
  assign ctrl_ena       = ena_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_tt_sel_pulser.sv
// Self-checking bench for tt_sel_pulser: per-cycle pad trace against a timing
// model, plus a scoreboard of pulse count and ena latency checked on done.
module tb_tt_sel_pulser;

  localparam int unsigned R = 4;
  localparam int unsigned H = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       busy;
  logic       done;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int unsigned pulses;
    int unsigned lat;
  } exp_t;
  exp_t sb_q[$];

  bit          acc_flag = 1'b0;
  int unsigned mon_k = 0;
  int unsigned mon_pulses = 0;
  logic        inc_prev = 1'b0;

  tt_sel_pulser dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .busy           (busy),
    .done           (done),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int unsigned addr);
    return 1 + R + H * (1 + 2 * addr);
  endfunction

  // Expected {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy} after edge k.
  function automatic logic [4:0] exp_vec(input int unsigned k, input int unsigned addr);
    int unsigned s, l;
    logic rn, in, en, dn, bz;
    s  = 1 + R + H;
    l  = lat_of(addr);
    rn = (k > R);
    in = (k >= s) && (k < l) && (((k - s) % (2 * H)) < H);
    en = (k >= l);
    dn = (k == l);
    bz = (k >= 1) && (k < l);
    return {rn, in, en, dn, bz};
  endfunction

  // Scoreboard side: count inc rising edges and latency since accept, compare on done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_pulses = 0;
        inc_prev   = 1'b0;
      end else if (acc_flag) begin
        acc_flag   = 1'b0;
        mon_k      = 0;
        mon_pulses = 0;
        inc_prev   = ctrl_sel_inc;
      end else begin
        mon_k = mon_k + 1;
        if (ctrl_sel_inc === 1'b1 && inc_prev !== 1'b1) mon_pulses = mon_pulses + 1;
        inc_prev = ctrl_sel_inc;
        if (done === 1'b1) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_done: got done=1 at k=%0d, required no pending request", mon_k);
          end else begin
            e = sb_q.pop_front();
            checks++;
            if (mon_pulses != e.pulses) begin
              errors++;
              $display("FAIL sb_pulses: got %0d pulses, required %0d", mon_pulses, e.pulses);
            end
            if (mon_k != e.lat) begin
              errors++;
              $display("FAIL sb_latency: got done at k=%0d, required k=%0d", mon_k, e.lat);
            end
          end
        end
      end
    end
  end

  task automatic run_seq(input int unsigned addr, input bit inject);
    int unsigned l;
    logic [4:0] got, exp;
    l = lat_of(addr);
    @(negedge clk);
    req_addr  = 10'(addr);
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_before_accept addr=%0d: got %b, required 1", addr, req_ready);
    end
    @(posedge clk);
    acc_flag = 1'b1;
    sb_q.push_back('{pulses: addr, lat: l});
    @(negedge clk);
    req_valid = 1'b0;
    for (int unsigned k = 1; k <= l; k++) begin
      @(negedge clk);
      got = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy};
      exp = exp_vec(k, addr);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL trace addr=%0d k=%0d: got rstn/inc/ena/done/busy=%b, required %b", addr, k, got, exp);
      end
      if (k == R + 1) begin
        checks++;
        if (req_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_busy addr=%0d: got %b, required 0", addr, req_ready);
        end
      end
      if (inject && k == 8) begin
        req_valid = 1'b1;
        req_addr  = 10'd5;
      end
      if (inject && k == 12) req_valid = 1'b0;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_ena addr=%0d: got %b, required 1", addr, req_ready);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_outputs: got rstn/inc/ena/done/busy/ready=%b, required 000001",
               {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ctrl_sel_rst_n !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: got rstn=%b busy=%b, required 0 0", ctrl_sel_rst_n, busy);
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    req_addr  = 10'd3;
    req_valid = 1'b1;
    @(posedge clk);
    acc_flag = 1'b1;
    sb_q.push_back('{pulses: 3, lat: lat_of(3)});
    @(negedge clk);
    req_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (ctrl_sel_inc !== 1'b1) begin
      errors++;
      $display("FAIL mid_inc_hi: got inc=%b at k=7, required 1", ctrl_sel_inc);
    end
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_addr  = 10'd2;
    @(negedge clk);
    void'(sb_q.pop_back());
    checks++;
    if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL mid_reset_outputs: got rstn/inc/ena/done/busy/ready=%b, required 000001",
               {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready});
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL req_during_reset_dropped: got rstn/inc/ena/busy=%b, required 0000",
               {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, busy});
    end
  endtask

  initial begin
    test_reset();
    run_seq(3, 1'b0);
    run_seq(0, 1'b0);
    run_seq(1023, 1'b0);
    run_seq(3, 1'b1);
    test_mid_reset();
    run_seq(5, 1'b0);
    run_seq(2, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending entries, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
